// File: rtl/io_port_hub_pkg.sv
// io_port_hub_pkg: shared widths and feature switch for io_port_hub.
// Defining IO_HUB_ITR_EN enables the data-arrival interrupt; it is off by default.
package io_port_hub_pkg;
  localparam int WORD_BITS = 16;
`ifdef IO_HUB_ITR_EN
  localparam bit ITR_EN = 1'b1;
`else
  localparam bit ITR_EN = 1'b0;
`endif
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/io_fifo.sv
// io_fifo: synchronous FIFO without fall-through, with a registered became-non-empty flag.
module io_fifo #(
  parameter int FDEPTH = 4,
  parameter int NUBITS = 16,
  parameter bit FLAG_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [NUBITS-1:0] din,
  output logic [NUBITS-1:0] head,
  output logic              full,
  output logic              empty,
  output logic              filled
);
  localparam int AW = $clog2(FDEPTH);
  logic [NUBITS-1:0] mem [FDEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(FDEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  if (FLAG_EN) begin : g_flag
    always_ff @(posedge clk or negedge rst)
      if (!rst) filled <= 1'b0;
      else filled <= empty & do_push;
  end else begin : g_noflag
    assign filled = 1'b0;
  end
endmodule

// File: rtl/io_port_hub.sv
// io_port_hub: per-address input FIFOs and output holding registers for the processor I/O bus.
// The itr pulse is built only when IO_HUB_ITR_EN is defined.
module io_port_hub
  import io_port_hub_pkg::*;
#(
  parameter int NUBITS = WORD_BITS,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_in,
  input  logic [addr_w(NUIOIN)-1:0]  addr_in,
  output logic [NUBITS-1:0]          io_in,
  input  logic                       out_en,
  input  logic [addr_w(NUIOOU)-1:0]  addr_out,
  input  logic [NUBITS-1:0]          io_out,
  output logic                       itr,
  input  logic [NUIOIN*NUBITS-1:0]   ext_in_data,
  input  logic [NUIOIN-1:0]          ext_in_valid,
  output logic [NUIOIN-1:0]          ext_in_ready,
  output logic [NUIOOU*NUBITS-1:0]   ext_out_data,
  output logic [NUIOOU-1:0]          ext_out_valid,
  input  logic [NUIOOU-1:0]          ext_out_ready,
  output logic [NUIOIN-1:0]          udf,
  output logic [NUIOOU-1:0]          ovr
);
  localparam int AIW = addr_w(NUIOIN);
  localparam int AOW = addr_w(NUIOOU);
  logic [NUBITS-1:0] head [NUIOIN];
  logic [NUBITS-1:0] last [NUIOIN];
  logic [NUIOIN-1:0] full, empty, filled, pop;
  for (genvar i = 0; i < NUIOIN; i++) begin : g_ch
    assign pop[i] = req_in && addr_in == AIW'(i);
    io_fifo #(.FDEPTH(FDEPTH), .NUBITS(NUBITS), .FLAG_EN(ITR_EN)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(ext_in_valid[i]),
      .pop(pop[i]),
      .din(ext_in_data[i*NUBITS +: NUBITS]),
      .head(head[i]),
      .full(full[i]),
      .empty(empty[i]),
      .filled(filled[i])
    );
  end
  assign ext_in_ready = {NUIOIN{rst}} & ~full;
  assign itr = |filled;
  // Out-of-range addresses match no channel and read as zero.
  always_comb begin
    io_in = '0;
    for (int k = 0; k < NUIOIN; k++)
      if (addr_in == AIW'(k)) io_in = empty[k] ? last[k] : head[k];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ext_out_data <= '0;
      ext_out_valid <= '0;
      ovr <= '0;
      udf <= '0;
      for (int k = 0; k < NUIOIN; k++) last[k] <= '0;
    end else begin
      for (int k = 0; k < NUIOIN; k++)
        if (pop[k]) begin
          if (empty[k]) udf[k] <= 1'b1;
          else last[k] <= head[k];
        end
      for (int k = 0; k < NUIOOU; k++)
        if (out_en && addr_out == AOW'(k)) begin
          ext_out_data[k*NUBITS +: NUBITS] <= io_out;
          ext_out_valid[k] <= 1'b1;
          if (ext_out_valid[k] && !ext_out_ready[k]) ovr[k] <= 1'b1;
        end else if (ext_out_ready[k]) ext_out_valid[k] <= 1'b0;
    end
endmodule

// File: tb/tb_io_port_hub.sv
// tb_io_port_hub: directed stimulus with a queue scoreboard for processor reads and consumer accepts.
module tb_io_port_hub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_in = 1'b0;
  logic [0:0] addr_in = '0;
  logic [15:0] io_in;
  logic out_en = 1'b0;
  logic [0:0] addr_out = '0;
  logic [15:0] io_out = '0;
  logic itr;
  logic [31:0] ext_in_data = '0;
  logic [1:0] ext_in_valid = '0;
  logic [1:0] ext_in_ready;
  logic [31:0] ext_out_data;
  logic [1:0] ext_out_valid;
  logic [1:0] ext_out_ready = '0;
  logic [1:0] udf, ovr;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_rd [$];
  logic [15:0] exp_out [$];
  int exp_ch [$];

  io_port_hub dut (
    .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
    .out_en(out_en), .addr_out(addr_out), .io_out(io_out), .itr(itr),
    .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
    .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
    .udf(udf), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && req_in) begin
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %h with no expected read", io_in);
      end else chk("io_in", {16'h0, io_in}, {16'h0, exp_rd.pop_front()});
    end
    for (int k = 0; k < 2; k++)
      if (rst && ext_out_valid[k] && ext_out_ready[k]) begin
        if (exp_out.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: ch %0d got %h with no expected accept", k, ext_out_data[k*16 +: 16]);
        end else begin
          chk("out_ch", k, exp_ch.pop_front());
          chk("out_data", {16'h0, ext_out_data[k*16 +: 16]}, {16'h0, exp_out.pop_front()});
        end
      end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_io_in", {16'h0, io_in}, 32'h0);
    chk("rst_ready", {30'h0, ext_in_ready}, 32'h0);
    chk("rst_valid", {30'h0, ext_out_valid}, 32'h0);
    chk("rst_data", ext_out_data, 32'h0);
    chk("rst_flags", {28'h0, udf, ovr}, 32'h0);
    chk("rst_itr", {31'h0, itr}, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    chk("ready_after_rst", {30'h0, ext_in_ready}, 32'h3);
    // basic read
    ext_in_data = 32'h0000_1234; ext_in_valid = 2'b01; tick();
    ext_in_data = 32'h0000_5678; tick();
    ext_in_valid = 2'b00;
    addr_in = 1'b0; req_in = 1'b1;
    exp_rd.push_back(16'h1234); tick();
    exp_rd.push_back(16'h5678); tick();
    chk("udf_after_reads", {30'h0, udf}, 32'h0);
    exp_rd.push_back(16'h5678); tick();
    req_in = 1'b0;
    chk("udf_empty_read", {30'h0, udf}, 32'h1);
    chk("ch1_ready", {30'h0, ext_in_ready}, 32'h3);
    // fill channel 1
    ext_in_valid = 2'b10;
    for (int i = 1; i <= 4; i++) begin
      ext_in_data = {16'hA000 + 16'(i), 16'h0};
      tick();
    end
    chk("full_ready", {30'h0, ext_in_ready}, 32'h1);
    ext_in_data = {16'hA005, 16'h0}; tick();
    ext_in_valid = 2'b00;
    addr_in = 1'b1; req_in = 1'b1;
    exp_rd.push_back(16'hA001); tick();
    req_in = 1'b0;
    chk("ready_after_pop", {30'h0, ext_in_ready}, 32'h3);
    req_in = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      exp_rd.push_back(16'hA000 + 16'(i));
      tick();
    end
    exp_rd.push_back(16'hA004); tick();
    req_in = 1'b0;
    chk("udf_both", {30'h0, udf}, 32'h3);
    // push and pop on the same edge
    addr_in = 1'b0;
    ext_in_data = 32'h0000_00B1; ext_in_valid = 2'b01; tick();
    ext_in_data = 32'h0000_00B2; req_in = 1'b1;
    exp_rd.push_back(16'h00B1); tick();
    ext_in_valid = 2'b00;
    exp_rd.push_back(16'h00B2); tick();
    exp_rd.push_back(16'h00B2); tick();
    req_in = 1'b0;
    // output handshake with overwrite
    out_en = 1'b1; addr_out = 1'b1; io_out = 16'h00AA; tick();
    chk("out_valid", {30'h0, ext_out_valid}, 32'h2);
    io_out = 16'h00BB; tick();
    out_en = 1'b0;
    chk("ovr_set", {30'h0, ovr}, 32'h2);
    chk("out_data_bb", {16'h0, ext_out_data[31:16]}, 32'h00BB);
    exp_ch.push_back(1); exp_out.push_back(16'h00BB);
    ext_out_ready = 2'b10; tick();
    chk("valid_cleared", {30'h0, ext_out_valid}, 32'h0);
    ext_out_ready = 2'b00;
    // write and accept on the same edge
    out_en = 1'b1; addr_out = 1'b0; io_out = 16'h0022; tick();
    exp_ch.push_back(0); exp_out.push_back(16'h0022);
    ext_out_ready = 2'b01; io_out = 16'h0011; tick();
    out_en = 1'b0;
    chk("wa_valid", {30'h0, ext_out_valid}, 32'h1);
    chk("wa_data", {16'h0, ext_out_data[15:0]}, 32'h0011);
    chk("wa_ovr", {30'h0, ovr}, 32'h2);
    exp_ch.push_back(0); exp_out.push_back(16'h0011);
    tick();
    chk("wa_cleared", {30'h0, ext_out_valid}, 32'h0);
    ext_out_ready = 2'b00;
    // interrupt on simultaneous first pushes
    ext_in_data = 32'h00C1_00C0; ext_in_valid = 2'b11; tick();
    ext_in_data = 32'h00C3_00C2; ext_in_valid = 2'b01;
`ifdef IO_HUB_ITR_EN
    chk("itr_pulse", {31'h0, itr}, 32'h1);
`else
    chk("itr_off", {31'h0, itr}, 32'h0);
`endif
    tick();
    ext_in_valid = 2'b00;
    chk("itr_one_cycle", {31'h0, itr}, 32'h0);
    tick();
    chk("itr_no_repeat", {31'h0, itr}, 32'h0);
    // asynchronous reset mid-stream
    addr_in = 1'b0;
    chk("pre_rst_io_in", {16'h0, io_in}, 32'h00C0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_io_in", {16'h0, io_in}, 32'h0);
    chk("mid_rst_ready", {30'h0, ext_in_ready}, 32'h0);
    chk("mid_rst_itr", {31'h0, itr}, 32'h0);
    chk("mid_rst_flags", {28'h0, udf, ovr}, 32'h0);
    tick();
    rst = 1'b1;
    req_in = 1'b1;
    exp_rd.push_back(16'h0000); tick();
    req_in = 1'b0;
    chk("post_rst_udf", {30'h0, udf}, 32'h1);
    tick();
    if (exp_rd.size() != 0 || exp_out.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", exp_rd.size(), exp_out.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
